uart_tx_feeder: RTL

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tx_feeder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: baud/oversampling figures, transmit feeder timing
// defaults and the feeder state encoding.
package uart_pkg;

   // Baud generation: the UART core clock runs at 16x the bit rate.
   localparam int unsigned CLK_HZ     = 50_000_000;
   localparam int unsigned BAUD_RATE  = 9_600;
   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned BAUD_DIV   = CLK_HZ / (BAUD_RATE * OVERSAMPLE);
   localparam int unsigned FRAME_BITS = 10;

   // Feeder timing defaults: 10 bits x 16 ticks plus 8 cycles of margin.
   localparam int unsigned FRAME_CYCLES_DEF  = FRAME_BITS * OVERSAMPLE + 8;
   localparam int unsigned STROBE_CYCLES_DEF = 2;

   // Datapath widths.
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned TX_CNT_W = 16;

   // Transmit feeder states.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      STB  = 3'd3,
      WAIT = 3'd4
   } feeder_state_e;

endpackage

// File: rtl/uart_tx_feeder.sv
// Feeds the UART transmitter one byte per frame, taking bytes either from a
// source FIFO or from the receiver (echo). Echo bytes win over FIFO bytes.
//
// Ports:
//   clk, rst_n          16x baud clock, async active-low reset
//   fifo_empty/_data    source FIFO status and read data (data valid the
//   fifo_rd             cycle after the one-cycle fifo_rd strobe)
//   echo_en             enable echoing of received bytes
//   rx_data, rx_rdsig   receiver byte and byte-done (rising edge = new byte)
//   tx_data, tx_wrsig   transmitter data and start strobe
//   busy                high whenever the FSM is not IDLE
//   echo_ovf            sticky: an echo byte was dropped
//   tx_count            bytes sent, modulo 2^16
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int unsigned FRAME_CYCLES  = FRAME_CYCLES_DEF,
   parameter int unsigned STROBE_CYCLES = STROBE_CYCLES_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                fifo_empty,
   input  logic [DATA_W-1:0]   fifo_data,
   output logic                fifo_rd,
   input  logic                echo_en,
   input  logic [DATA_W-1:0]   rx_data,
   input  logic                rx_rdsig,
   output logic [DATA_W-1:0]   tx_data,
   output logic                tx_wrsig,
   output logic                busy,
   output logic                echo_ovf,
   output logic [TX_CNT_W-1:0] tx_count
);

   localparam int unsigned CNT_W = $clog2(FRAME_CYCLES + 1);

   feeder_state_e       state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   tx_data_q, tx_data_d;
   logic [TX_CNT_W-1:0] tx_count_q, tx_count_d;
   logic                fifo_rd_q, fifo_rd_d;
   logic                tx_wrsig_q, tx_wrsig_d;
   logic                busy_q, busy_d;
   logic [DATA_W-1:0]   echo_buf_q, echo_buf_d;
   logic                echo_pend_q, echo_pend_d;
   logic                echo_ovf_q, echo_ovf_d;
   logic                rx_q;

   logic                rx_rise;
   logic                echo_take;
   logic                echo_consume;
   logic                stb_entry;

   // Receiver byte-done edge detect against the one-cycle history.
   assign rx_rise   = rx_rdsig & ~rx_q;
   assign echo_take = rx_rise & echo_en;

   // Next-state and registered-output decode.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      tx_data_d    = tx_data_q;
      echo_consume = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (echo_pend_q) begin
               state_d      = STB;
               tx_data_d    = echo_buf_q;
               echo_consume = 1'b1;
            end else if (!fifo_empty) begin
               state_d = RD;
            end
         end
         RD: begin
            cnt_d   = '0;
            state_d = CAP;
         end
         CAP: begin
            cnt_d     = '0;
            tx_data_d = fifo_data;
            state_d   = STB;
         end
         // cnt_q counts cycles since the first STB cycle across STB and WAIT.
         STB: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(STROBE_CYCLES - 1)) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FRAME_CYCLES - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Outputs are registered copies of the state being entered.
      stb_entry  = (state_d == STB) && (state_q != STB);
      fifo_rd_d  = (state_d == RD);
      tx_wrsig_d = (state_d == STB);
      busy_d     = (state_d != IDLE);
      tx_count_d = tx_count_q + TX_CNT_W'(stb_entry);
   end

   // Echo buffer: a byte arriving on the consume cycle refills the buffer.
   always_comb begin
      echo_buf_d  = echo_buf_q;
      echo_pend_d = echo_pend_q;
      echo_ovf_d  = echo_ovf_q;

      if (echo_consume) begin
         echo_pend_d = 1'b0;
      end
      if (echo_take) begin
         if (!echo_pend_q || echo_consume) begin
            echo_buf_d  = rx_data;
            echo_pend_d = 1'b1;
         end else begin
            echo_ovf_d = 1'b1;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         tx_data_q   <= '0;
         tx_count_q  <= '0;
         fifo_rd_q   <= 1'b0;
         tx_wrsig_q  <= 1'b0;
         busy_q      <= 1'b0;
         echo_buf_q  <= '0;
         echo_pend_q <= 1'b0;
         echo_ovf_q  <= 1'b0;
         rx_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tx_data_q   <= tx_data_d;
         tx_count_q  <= tx_count_d;
         fifo_rd_q   <= fifo_rd_d;
         tx_wrsig_q  <= tx_wrsig_d;
         busy_q      <= busy_d;
         echo_buf_q  <= echo_buf_d;
         echo_pend_q <= echo_pend_d;
         echo_ovf_q  <= echo_ovf_d;
         rx_q        <= rx_rdsig;
      end
   end

   assign fifo_rd  = fifo_rd_q;
   assign tx_data  = tx_data_q;
   assign tx_wrsig = tx_wrsig_q;
   assign busy     = busy_q;
   assign echo_ovf = echo_ovf_q;
   assign tx_count = tx_count_q;

endmodule
